// File: rtl/debug_run_ctrl.sv
// debug_run_ctrl: UART-driven run control for the 5-stage MIPS pipeline.
// Gates the pipeline clock enable (halted / free-run / single-step) and, on
// every stop or on request, streams a 12-byte snapshot {pc, cycle_count, reg0}
// MSB first to the UART transmitter.
module debug_run_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 32,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] reg0,
    input  logic [5:0]        instr_op,
    output logic              pipe_en,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              halted
);

    localparam logic [7:0]       CMD_RUN   = 8'h63;  // 'c'
    localparam logic [7:0]       CMD_STEP  = 8'h73;  // 's'
    localparam logic [7:0]       CMD_HALT  = 8'h68;  // 'h'
    localparam logic [7:0]       CMD_DUMP  = 8'h64;  // 'd'
    localparam logic [3:0]       LAST_BYTE = 4'd11;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_SNAP,
        S_SEND,
        S_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [3:0]       byte_idx;
    logic             guard;      // high during the first WAIT cycle (tx_start cycle)
    logic [0:11][7:0] snapshot;   // element 0 is the first byte sent
    logic [31:0]      pc_lo, cnt_lo, reg0_lo;
    logic             cmd_run, cmd_step, cmd_halt, cmd_dump;
    logic             send_fire, wait_done;

    assign cmd_run  = rx_valid && (rx_data == CMD_RUN);
    assign cmd_step = rx_valid && (rx_data == CMD_STEP);
    assign cmd_halt = rx_valid && (rx_data == CMD_HALT);
    assign cmd_dump = rx_valid && (rx_data == CMD_DUMP);

    assign halted = (state == S_IDLE);

    // The dump always carries exactly 32 bits per field: truncate wide words,
    // zero-extend narrow ones.
    if (DATA_W >= 32) begin : g_word_trunc
        assign pc_lo   = pc[31:0];
        assign reg0_lo = reg0[31:0];
    end else begin : g_word_ext
        assign pc_lo   = {{(32-DATA_W){1'b0}}, pc};
        assign reg0_lo = {{(32-DATA_W){1'b0}}, reg0};
    end

    if (CNT_W >= 32) begin : g_cnt_trunc
        assign cnt_lo = cycle_count[31:0];
    end else begin : g_cnt_ext
        assign cnt_lo = {{(32-CNT_W){1'b0}}, cycle_count};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and the TX handshake strobes.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch behind.
        state_nxt = state;
        send_fire = 1'b0;
        wait_done = 1'b0;
        unique case (state)
            S_IDLE: begin
                if      (cmd_run)  state_nxt = S_RUN;
                else if (cmd_step) state_nxt = S_STEP;
                else if (cmd_dump) state_nxt = S_SNAP;
            end
            S_RUN: begin
                // 'h' and the HALT opcode may coincide; either stops the run once.
                if (cmd_halt || (instr_op == HALT_OP)) state_nxt = S_SNAP;
            end
            S_STEP: state_nxt = S_SNAP;
            S_SNAP: state_nxt = S_SEND;
            S_SEND: begin
                if (!tx_busy) begin
                    send_fire = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // tx_busy only rises the cycle after tx_start, so the guard
                // cycle must not mistake the still-low busy for "done".
                if (!guard && !tx_busy) begin
                    wait_done = 1'b1;
                    state_nxt = (byte_idx == LAST_BYTE) ? S_IDLE : S_SEND;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered pipeline enable and saturating executed-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_en     <= 1'b0;
            cycle_count <= '0;
        end else begin
            pipe_en <= (state_nxt == S_RUN) || (state_nxt == S_STEP);
            if (pipe_en && (cycle_count != CNT_MAX))
                cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    // Snapshot capture and byte index sequencing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: this snapshot is plain flops with a defined reset value, not a RAM.
            snapshot <= '0;
            byte_idx <= '0;
        end else if (state == S_SNAP) begin
            snapshot <= {pc_lo, cnt_lo, reg0_lo};
            byte_idx <= '0;
        end else if (wait_done && (byte_idx != LAST_BYTE)) begin
            byte_idx <= byte_idx + 4'd1;
        end
    end

    // Registered TX strobe/data and the WAIT guard flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
            guard    <= 1'b0;
        end else begin
            tx_start <= send_fire;
            guard    <= send_fire;
            if (send_fire) tx_data <= snapshot[byte_idx];
        end
    end

endmodule

// File: tb/tb_debug_run_ctrl.sv
// tb_debug_run_ctrl: randomized scoreboard bench for debug_run_ctrl.
// Stimulus tasks push each expected 12-byte dump into a queue; a monitor pops
// and compares on every tx_start. A small UART model drives tx_busy.
`timescale 1ns/1ps
module tb_debug_run_ctrl;

    localparam int          DATA_W   = 32;
    localparam int          CNT_W    = 32;
    localparam logic [5:0]  HALT_OP  = 6'h3F;
    localparam logic [7:0]  CMD_RUN  = 8'h63;
    localparam logic [7:0]  CMD_STEP = 8'h73;
    localparam logic [7:0]  CMD_HALT = 8'h68;
    localparam logic [7:0]  CMD_DUMP = 8'h64;
    localparam logic [7:0]  CMD_X    = 8'h78;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] reg0;
    logic [5:0]        instr_op;
    logic              pipe_en;
    logic [CNT_W-1:0]  cycle_count;
    logic              halted;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    int          tx_seen = 0;
    bit          force_busy = 1'b0;
    logic [31:0] exp_count = '0;

    debug_run_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .HALT_OP(HALT_OP)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .pc(pc), .reg0(reg0), .instr_op(instr_op), .pipe_en(pipe_en),
        .cycle_count(cycle_count), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: executed cycles saturate at all-ones.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input int n);
        longint s;
        s = longint'(a) + longint'(n);
        return (s > longint'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Reference: a dump is pc, count, reg0, each 32-bit big-endian.
    task automatic push_dump(input logic [31:0] p, input logic [31:0] c, input logic [31:0] r);
        logic [95:0] w;
        w = {p, c, r};
        for (int i = 0; i < 12; i++) exp_q.push_back(w[95-8*i -: 8]);
    endtask

    function automatic logic [7:0] noise_byte(input bit no_halt);
        logic [7:0] b;
        case ($urandom_range(0, 5))
            0:       b = CMD_RUN;
            1:       b = CMD_STEP;
            2:       b = CMD_DUMP;
            3:       b = CMD_HALT;
            4:       b = CMD_X;
            default: b = 8'($urandom);
        endcase
        if (no_halt && b == CMD_HALT) b = CMD_X;
        return b;
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic cmd(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic tick_noise(input bit no_halt);
        if ($urandom_range(0, 3) == 0) begin
            rx_valid = 1'b1;
            rx_data  = noise_byte(no_halt);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic set_operands();
        pc       = $urandom;
        reg0     = $urandom;
        instr_op = 6'($urandom_range(0, 62));
    endtask

    task automatic wait_idle(input string name);
        int n;
        int pipe_bad;
        n = 0;
        pipe_bad = 0;
        while (!(halted === 1'b1 && exp_q.size() == 0) && n < 2000) begin
            if (pipe_en !== 1'b0) pipe_bad++;
            if (halted === 1'b1) @(negedge clk);
            else tick_noise(1'b0);
            n++;
        end
        check({name, "_dump_timeout"}, 64'(n < 2000), 64'd1);
        check({name, "_pipe_en_in_dump"}, 64'(pipe_bad), 64'd0);
        check({name, "_cycle_count"}, 64'(cycle_count), 64'(exp_count));
        check({name, "_halted"}, 64'(halted), 64'd1);
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        check("reset_tx_start", 64'(tx_start), 64'd0);
        check("reset_tx_data", 64'(tx_data), 64'd0);
        check("reset_halted", 64'(halted), 64'd1);
        check("reset_pipe_en", 64'(pipe_en), 64'd0);
        check("reset_cycle_count", 64'(cycle_count), 64'd0);
        exp_q.delete();
        exp_count = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_step();
        set_operands();
        exp_count = sat_add(exp_count, 1);
        push_dump(pc, exp_count, reg0);
        cmd(CMD_STEP);
        check("step_pipe_en_on", 64'(pipe_en), 64'd1);
        check("step_not_halted", 64'(halted), 64'd0);
        @(negedge clk);
        check("step_pipe_en_off", 64'(pipe_en), 64'd0);
        wait_idle("step");
    endtask

    // mode 0: stop by 'h'; 1: stop by HALT opcode; 2: both in the same cycle.
    task automatic do_run(input int idle, input int mode, input bit noise);
        int bad;
        bad = 0;
        set_operands();
        cmd(CMD_RUN);
        for (int i = 0; i < idle; i++) begin
            if (pipe_en !== 1'b1) bad++;
            if (noise) tick_noise(1'b1);
            else @(negedge clk);
        end
        if (pipe_en !== 1'b1) bad++;
        check("run_pipe_en_on", 64'(bad), 64'd0);
        exp_count = sat_add(exp_count, idle + 1);
        push_dump(pc, exp_count, reg0);
        if (mode != 0) instr_op = HALT_OP;
        if (mode != 1) begin
            rx_valid = 1'b1;
            rx_data  = CMD_HALT;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        instr_op = 6'($urandom_range(0, 62));
        check("run_pipe_en_off", 64'(pipe_en), 64'd0);
        check("run_not_halted_in_snap", 64'(halted), 64'd0);
        wait_idle("run");
    endtask

    task automatic do_dump();
        set_operands();
        push_dump(pc, exp_count, reg0);
        cmd(CMD_DUMP);
        wait_idle("dump");
    endtask

    // UART transmitter model: busy rises the cycle after tx_start.
    initial begin : uart_model
        int busy_left;
        bit rise_pend;
        busy_left = 0;
        rise_pend = 1'b0;
        tx_busy   = 1'b0;
        forever begin
            @(negedge clk);
            if (rise_pend) busy_left = $urandom_range(1, 5);
            else if (busy_left > 0) busy_left--;
            rise_pend = (tx_start === 1'b1);
            tx_busy   = (busy_left > 0) || force_busy;
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx_start === 1'b1) begin
                tx_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tx_unexpected: got byte 0x%0h, expected no transmission (t=%0t)", tx_data, $time);
                end else begin
                    check("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        int bad;
        int seen0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        pc       = '0;
        reg0     = '0;
        instr_op = '0;
        repeat (2) @(negedge clk);
        check("por_halted", 64'(halted), 64'd1);
        check("por_pipe_en", 64'(pipe_en), 64'd0);
        check("por_tx_start", 64'(tx_start), 64'd0);
        check("por_tx_data", 64'(tx_data), 64'd0);
        check("por_cycle_count", 64'(cycle_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single step from reset: one enabled cycle, count 1.
        do_step();

        // Dump latency with an idle UART: tx_start 3 cycles after rx_valid.
        set_operands();
        push_dump(pc, exp_count, reg0);
        cmd(CMD_DUMP);
        check("lat_cycle1", 64'(tx_start), 64'd0);
        @(negedge clk);
        check("lat_cycle2", 64'(tx_start), 64'd0);
        @(negedge clk);
        check("lat_cycle3", 64'(tx_start), 64'd1);
        wait_idle("latency");

        // Run 40 cycles then 'h': 41 enabled cycles.
        do_reset();
        do_run(40, 0, 1'b0);

        // HALT opcode at run cycle 5.
        do_reset();
        do_run(4, 1, 1'b0);
        check("haltop_count_5", 64'(cycle_count), 64'd5);

        // 'h' and HALT opcode together: one dump only.
        do_run(7, 2, 1'b0);

        // UART held busy for 50 cycles during SEND.
        set_operands();
        push_dump(pc, exp_count, reg0);
        force_busy = 1'b1;
        cmd(CMD_DUMP);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx_start !== 1'b0) bad++;
            @(negedge clk);
        end
        check("busy_hold_no_start", 64'(bad), 64'd0);
        force_busy = 1'b0;
        wait_idle("busy_hold");

        // Ignored bytes in IDLE and during a dump.
        seen0 = tx_seen;
        cmd(CMD_X);
        check("idle_x_halted", 64'(halted), 64'd1);
        cmd(CMD_HALT);
        check("idle_h_halted", 64'(halted), 64'd1);
        check("idle_h_pipe_en", 64'(pipe_en), 64'd0);
        repeat (5) @(negedge clk);
        check("idle_no_tx", 64'(tx_seen), 64'(seen0));
        set_operands();
        push_dump(pc, exp_count, reg0);
        cmd(CMD_DUMP);
        cmd(CMD_RUN);
        cmd(CMD_X);
        cmd(CMD_DUMP);
        wait_idle("dump_with_cmds");

        // Reset after byte 5 of a dump aborts it.
        do_run(12, 0, 1'b1);
        set_operands();
        push_dump(pc, exp_count, reg0);
        seen0 = tx_seen;
        cmd(CMD_DUMP);
        n = 0;
        while (tx_seen < seen0 + 6 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_byte5", 64'(n < 1000), 64'd1);
        do_reset();
        seen0 = tx_seen;
        repeat (20) @(negedge clk);
        check("abort_no_more_tx", 64'(tx_seen), 64'(seen0));
        do_dump();

        // Randomized mix.
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 5))
                0: do_step();
                1: do_run($urandom_range(0, 30), 0, 1'b1);
                2: do_run($urandom_range(0, 30), 1, 1'b1);
                3: do_run($urandom_range(0, 30), 2, 1'b1);
                4: do_dump();
                default: begin
                    cmd(($urandom_range(0, 1) == 0) ? CMD_HALT : CMD_X);
                    check("rand_idle_halted", 64'(halted), 64'd1);
                end
            endcase
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
